// File: rtl/dsp_mac_seq_if.sv
// Operand, result, job-control and DSP-side signals of the MAC sequencer.
// The sequencer connects through the slave modport; the modport directions follow the sequencer's port directions.
interface dsp_mac_seq_if #(
    parameter int NBITS_A = 20,
    parameter int NBITS_B = 18,
    parameter int NBITS_Z = 38
);
    logic               start_i;
    logic [5:0]         ntaps_i;
    logic               busy_o;
    logic               op_valid_i;
    logic               op_ready_o;
    logic [NBITS_A-1:0] op_a_i;
    logic [NBITS_B-1:0] op_b_i;
    logic [NBITS_A-1:0] dsp_a_o;
    logic [NBITS_B-1:0] dsp_b_o;
    logic               dsp_load_acc_o;
    logic [2:0]         dsp_feedback_o;
    logic [NBITS_Z-1:0] dsp_z_i;
    logic               res_valid_o;
    logic               res_ready_i;
    logic [NBITS_Z-1:0] res_data_o;
    logic               err_o;

    modport master (
        output start_i, ntaps_i, op_valid_i, op_a_i, op_b_i, dsp_z_i, res_ready_i,
        input  busy_o, op_ready_o, dsp_a_o, dsp_b_o, dsp_load_acc_o, dsp_feedback_o,
               res_valid_o, res_data_o, err_o
    );

    modport slave (
        input  start_i, ntaps_i, op_valid_i, op_a_i, op_b_i, dsp_z_i, res_ready_i,
        output busy_o, op_ready_o, dsp_a_o, dsp_b_o, dsp_load_acc_o, dsp_feedback_o,
               res_valid_o, res_data_o, err_o
    );
endinterface

// File: rtl/dsp_mac_seq.sv
// Multi-tap MAC sequencer that feeds an external accumulating DSP and captures its result.
// Optional ACCUM starvation watchdog: define DSP_MAC_SEQ_TIMEOUT_EN.
module dsp_mac_seq #(
    parameter int NBITS_A = 20,
    parameter int NBITS_B = 18,
    parameter int NBITS_Z = 38,
    parameter int DSP_LAT = 1
) (
    input  logic          clock_i,
    input  logic          reset_i,
    dsp_mac_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t             state, state_nx;
    logic [5:0]         ntaps_q;
    logic [5:0]         tap_cnt;
    logic [2:0]         drain_cnt;
    logic [NBITS_A-1:0] dsp_a_q;
    logic [NBITS_B-1:0] dsp_b_q;
    logic               load_acc_q;
    logic [2:0]         feedback_q;
    logic               res_valid_q;
    logic [NBITS_Z-1:0] res_data_q;
    logic               hs;
    logic               timeout;
    logic               drain_done;

`ifdef DSP_MAC_SEQ_TIMEOUT_EN
    logic [7:0] wd_cnt;

    assign timeout   = (state == ACCUM) && (wd_cnt == '1);
    assign bus.err_o = timeout;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wd_cnt <= '0;
        end else if (state == ACCUM && !bus.op_valid_i) begin
            wd_cnt <= wd_cnt + 8'd1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign timeout   = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    // Acceptance is withheld on the timeout cycle so a late operand cannot race the abort.
    assign bus.op_ready_o = (state == ACCUM) && !timeout;
    assign bus.busy_o     = (state != IDLE);
    assign hs             = bus.op_valid_i && bus.op_ready_o;
    assign drain_done     = (state == DRAIN) && (drain_cnt == 3'(DSP_LAT));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start_i) state_nx = ACCUM;
            ACCUM: begin
                if (timeout)                       state_nx = IDLE;
                else if (hs && tap_cnt == ntaps_q) state_nx = DRAIN;
            end
            DRAIN:   if (drain_done) state_nx = HOLD;
            HOLD:    if (bus.res_ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ntaps_q     <= '0;
            tap_cnt     <= '0;
            drain_cnt   <= '0;
            dsp_a_q     <= '0;
            dsp_b_q     <= '0;
            load_acc_q  <= 1'b0;
            feedback_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            load_acc_q <= hs;
            feedback_q <= '0;
            if (state == IDLE && bus.start_i) begin
                ntaps_q <= bus.ntaps_i;
                tap_cnt <= '0;
            end
            // First tap reloads the DSP accumulator, discarding whatever a previous job left.
            if (hs) begin
                dsp_a_q    <= bus.op_a_i;
                dsp_b_q    <= bus.op_b_i;
                feedback_q <= (tap_cnt == '0) ? 3'b001 : 3'b000;
                tap_cnt    <= tap_cnt + 6'd1;
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
            else                drain_cnt <= '0;
            if (drain_done) begin
                res_data_q  <= bus.dsp_z_i;
                res_valid_q <= 1'b1;
            end else if (state == HOLD && bus.res_ready_i) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.dsp_a_o        = dsp_a_q;
    assign bus.dsp_b_o        = dsp_b_q;
    assign bus.dsp_load_acc_o = load_acc_q;
    assign bus.dsp_feedback_o = feedback_q;
    assign bus.res_valid_o    = res_valid_q;
    assign bus.res_data_o     = res_data_q;
endmodule

// File: tb/tb_dsp_mac_seq.sv
// Directed bench for dsp_mac_seq with a behavioural signed-multiply accumulating DSP (DSP_LAT=1).
module tb_dsp_mac_seq;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    dsp_mac_seq_if #(.NBITS_A(20), .NBITS_B(18), .NBITS_Z(38)) bus ();

    dsp_mac_seq #(
        .NBITS_A(20), .NBITS_B(18), .NBITS_Z(38), .DSP_LAT(1)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    // DSP model: accumulator register is the single latency stage, z is the accumulator.
    logic signed [37:0] acc;
    logic signed [37:0] sa, sb, prod;
    always_comb begin
        sa   = {{18{bus.dsp_a_o[19]}}, bus.dsp_a_o};
        sb   = {{20{bus.dsp_b_o[17]}}, bus.dsp_b_o};
        prod = sa * sb;
    end
    always_ff @(posedge clk) begin
        if (bus.dsp_load_acc_o) acc <= ((bus.dsp_feedback_o == 3'b001) ? 38'sd0 : acc) + prod;
    end
    assign bus.dsp_z_i = acc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
        total++; if (bus.op_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.op_ready_o); end
        total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.res_valid_o); end
        total++; if (bus.res_data_o !== 38'd0) begin bad++; $display("FAIL reset_data got=%0h exp=0", bus.res_data_o); end
        total++; if (bus.dsp_load_acc_o !== 1'b0) begin bad++; $display("FAIL reset_load got=%b exp=0", bus.dsp_load_acc_o); end
        total++; if (bus.dsp_feedback_o !== 3'b000) begin bad++; $display("FAIL reset_fb got=%b exp=000", bus.dsp_feedback_o); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err_o); end
    endtask

    task automatic test_continuous();
        logic [19:0] av [4];
        logic [17:0] bv [4];
        av = '{20'd1, 20'd2, 20'd3, 20'd4};
        bv = '{18'd5, 18'd6, 18'd7, 18'd8};
        bus.start_i = 1'b1; bus.ntaps_i = 6'd3;
        bus.op_valid_i = 1'b1; bus.op_a_i = av[0]; bus.op_b_i = bv[0];
        tick();
        bus.start_i = 1'b0;
        total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL cont_busy got=%b exp=1", bus.busy_o); end
        total++; if (bus.op_ready_o !== 1'b1) begin bad++; $display("FAIL cont_ready got=%b exp=1", bus.op_ready_o); end
        total++; if (bus.dsp_load_acc_o !== 1'b0) begin bad++; $display("FAIL cont_noload_on_start got=%b exp=0", bus.dsp_load_acc_o); end
        for (int i = 0; i < 4; i++) begin
            bus.op_a_i = av[i]; bus.op_b_i = bv[i];
            tick();
            total++; if (bus.dsp_load_acc_o !== 1'b1) begin bad++; $display("FAIL cont_load tap=%0d got=%b exp=1", i, bus.dsp_load_acc_o); end
            total++; if (bus.dsp_a_o !== av[i] || bus.dsp_b_o !== bv[i]) begin bad++; $display("FAIL cont_ab tap=%0d got=%0d,%0d exp=%0d,%0d", i, bus.dsp_a_o, bus.dsp_b_o, av[i], bv[i]); end
            total++; if (bus.dsp_feedback_o !== ((i == 0) ? 3'b001 : 3'b000)) begin bad++; $display("FAIL cont_fb tap=%0d got=%b", i, bus.dsp_feedback_o); end
        end
        bus.op_valid_i = 1'b0;
        tick();
        total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL cont_early_valid edge=5 got=%b exp=0", bus.res_valid_o); end
        total++; if (bus.op_ready_o !== 1'b0) begin bad++; $display("FAIL cont_drain_ready got=%b exp=0", bus.op_ready_o); end
        tick();
        total++; if (bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL cont_valid edge=6 got=%b exp=1", bus.res_valid_o); end
        total++; if (bus.res_data_o !== 38'd70) begin bad++; $display("FAIL cont_data got=%0d exp=70", bus.res_data_o); end
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
        total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL cont_consume_valid got=%b exp=0", bus.res_valid_o); end
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL cont_idle_busy got=%b exp=0", bus.busy_o); end
    endtask

    task automatic test_gaps();
        logic [19:0] av [4];
        logic [17:0] bv [4];
        int          k;
        av = '{20'd1, 20'd2, 20'd3, 20'd4};
        bv = '{18'd5, 18'd6, 18'd7, 18'd8};
        bus.start_i = 1'b1; bus.ntaps_i = 6'd3; bus.op_valid_i = 1'b0;
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.op_valid_i = 1'b1; bus.op_a_i = av[i]; bus.op_b_i = bv[i];
            tick();
            bus.op_valid_i = 1'b0; bus.op_a_i = 20'hAAAAA; bus.op_b_i = 18'h15555;
            total++; if (bus.dsp_load_acc_o !== 1'b1) begin bad++; $display("FAIL gap_load tap=%0d got=%b exp=1", i, bus.dsp_load_acc_o); end
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    total++; if (bus.dsp_load_acc_o !== 1'b0) begin bad++; $display("FAIL gap_hold_load tap=%0d gap=%0d got=%b exp=0", i, g, bus.dsp_load_acc_o); end
                    total++; if (bus.dsp_a_o !== av[i]) begin bad++; $display("FAIL gap_hold_a tap=%0d got=%0d exp=%0d", i, bus.dsp_a_o, av[i]); end
                end
            end
        end
        k = 0;
        while (k < 20 && bus.res_valid_o !== 1'b1) begin tick(); k++; end
        total++; if (bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL gap_wait_valid got=%b exp=1", bus.res_valid_o); end
        total++; if (bus.res_data_o !== 38'd70) begin bad++; $display("FAIL gap_data got=%0d exp=70", bus.res_data_o); end
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
    endtask

    task automatic test_hold();
        int k;
        bus.start_i = 1'b1; bus.ntaps_i = 6'd0;
        bus.op_valid_i = 1'b1; bus.op_a_i = 20'd3; bus.op_b_i = 18'd4;
        tick();
        bus.start_i = 1'b0;
        tick();
        bus.op_valid_i = 1'b0;
        k = 0;
        while (k < 20 && bus.res_valid_o !== 1'b1) begin tick(); k++; end
        total++; if (bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL hold_wait_valid got=%b exp=1", bus.res_valid_o); end
        bus.start_i = 1'b1; bus.ntaps_i = 6'd5; bus.op_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++; if (bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", c, bus.res_valid_o); end
            total++; if (bus.res_data_o !== 38'd12) begin bad++; $display("FAIL hold_data cyc=%0d got=%0d exp=12", c, bus.res_data_o); end
            total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL hold_busy cyc=%0d got=%b exp=1", c, bus.busy_o); end
            total++; if (bus.op_ready_o !== 1'b0) begin bad++; $display("FAIL hold_ready cyc=%0d got=%b exp=0", c, bus.op_ready_o); end
        end
        bus.start_i = 1'b0; bus.op_valid_i = 1'b0; bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
        total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%b exp=0", bus.res_valid_o); end
        tick();
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL hold_no_new_job got=%b exp=0", bus.busy_o); end
    endtask

    task automatic test_single_negative();
        int k;
        bus.start_i = 1'b1; bus.ntaps_i = 6'd0; bus.op_valid_i = 1'b0;
        tick();
        bus.start_i = 1'b0;
        bus.op_valid_i = 1'b1; bus.op_a_i = 20'hFFFFD; bus.op_b_i = 18'd7;
        tick();
        bus.op_valid_i = 1'b0;
        total++; if (bus.dsp_feedback_o !== 3'b001) begin bad++; $display("FAIL neg_fb got=%b exp=001", bus.dsp_feedback_o); end
        total++; if (bus.dsp_load_acc_o !== 1'b1) begin bad++; $display("FAIL neg_load got=%b exp=1", bus.dsp_load_acc_o); end
        k = 0;
        while (k < 20 && bus.res_valid_o !== 1'b1) begin tick(); k++; end
        total++; if (bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL neg_wait_valid got=%b exp=1", bus.res_valid_o); end
        total++; if (bus.res_data_o !== 38'h3FFFFFFFEB) begin bad++; $display("FAIL neg_data got=%0h exp=3fffffffeb", bus.res_data_o); end
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
    endtask

    task automatic test_reset_midjob();
        int k;
        bus.start_i = 1'b1; bus.ntaps_i = 6'd3;
        bus.op_valid_i = 1'b1; bus.op_a_i = 20'd1; bus.op_b_i = 18'd5;
        tick();
        bus.start_i = 1'b0;
        tick();
        bus.op_a_i = 20'd2; bus.op_b_i = 18'd6;
        tick();
        rst = 1'b1;
        #1;
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL async_busy got=%b exp=0", bus.busy_o); end
        total++; if (bus.dsp_load_acc_o !== 1'b0) begin bad++; $display("FAIL async_load got=%b exp=0", bus.dsp_load_acc_o); end
        total++; if (bus.op_ready_o !== 1'b0) begin bad++; $display("FAIL async_ready got=%b exp=0", bus.op_ready_o); end
        total++; if (bus.dsp_a_o !== 20'd0 || bus.dsp_b_o !== 18'd0) begin bad++; $display("FAIL async_ab got=%0d,%0d exp=0,0", bus.dsp_a_o, bus.dsp_b_o); end
        total++; if (bus.dsp_feedback_o !== 3'b000) begin bad++; $display("FAIL async_fb got=%b exp=000", bus.dsp_feedback_o); end
        bus.op_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        bus.start_i = 1'b1; bus.ntaps_i = 6'd1;
        bus.op_valid_i = 1'b1; bus.op_a_i = 20'd2; bus.op_b_i = 18'd3;
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        bus.op_valid_i = 1'b0;
        k = 0;
        while (k < 20 && bus.res_valid_o !== 1'b1) begin tick(); k++; end
        total++; if (bus.res_valid_o !== 1'b1) begin bad++; $display("FAIL rst_job_wait_valid got=%b exp=1", bus.res_valid_o); end
        total++; if (bus.res_data_o !== 38'd12) begin bad++; $display("FAIL rst_job_data got=%0d exp=12", bus.res_data_o); end
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
    endtask

    task automatic test_watchdog();
        int errs;
        errs = 0;
        bus.start_i = 1'b1; bus.ntaps_i = 6'd0; bus.op_valid_i = 1'b0;
        tick();
        bus.start_i = 1'b0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (bus.err_o === 1'b1) errs++;
        end
`ifdef DSP_MAC_SEQ_TIMEOUT_EN
        total++; if (errs !== 1) begin bad++; $display("FAIL wd_pulses got=%0d exp=1", errs); end
        total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL wd_idle got=%b exp=0", bus.busy_o); end
        total++; if (bus.res_valid_o !== 1'b0) begin bad++; $display("FAIL wd_no_result got=%b exp=0", bus.res_valid_o); end
`else
        total++; if (errs !== 0) begin bad++; $display("FAIL wd_pulses got=%0d exp=0", errs); end
        total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL wd_still_busy got=%b exp=1", bus.busy_o); end
        total++; if (bus.op_ready_o !== 1'b1) begin bad++; $display("FAIL wd_still_accum got=%b exp=1", bus.op_ready_o); end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.start_i = 1'b0; bus.ntaps_i = '0;
        bus.op_valid_i = 1'b0; bus.op_a_i = '0; bus.op_b_i = '0;
        bus.res_ready_i = 1'b0;
        #12;
        test_reset();
        rst = 1'b0;
        tick();
        test_continuous();
        test_gaps();
        test_hold();
        test_single_negative();
        test_reset_midjob();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
